// File: rtl/cpu_mem_bridge_if.sv
// Memory-side req/ack port of the CPU bridge: one 16-bit beat per handshake.
interface cpu_mem_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Splits CPU 8/16/32/48-bit requests into 16-bit req/ack beats and stalls
// the core through cpu_enable until the transfer has completed.
module cpu_mem_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_req_sz,
    input  logic [31:0]       cpu_wdata,
    output logic [47:0]       cpu_data_in,
    output logic              cpu_enable,
    output logic              cpu_misalign,
    cpu_mem_bridge_if.master  mem
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        sz_q, k_q, last_q;
    logic              we_q;
    logic [31:0]       wdata_q;

    logic              req_pend, beat_done;
    logic [1:0]        req_sz_eff;
    logic [ADDR_W-1:0] src_addr, beat_addr;
    logic [1:0]        src_sz, src_k, beat_be;
    logic [31:0]       src_wdata;
    logic [15:0]       beat_wdata;

    assign req_pend   = cpu_rd_en | cpu_wr_en;
    // Only reads can be 48-bit; a 48-bit write collapses to 32-bit.
    assign req_sz_eff = (!cpu_rd_en && cpu_req_sz == 2'd3) ? 2'd2 : cpu_req_sz;
    assign beat_done  = (state == BEAT) && mem.mem_req && mem.mem_ack;

    // Beat fields are prepared one step ahead: from the CPU inputs when the
    // first beat launches, otherwise from the latched request for beat k+1.
    always_comb begin
        src_addr  = addr_q;
        src_sz    = sz_q;
        src_wdata = wdata_q;
        src_k     = k_q + 2'd1;
        if (state == IDLE) begin
            src_addr  = cpu_addr;
            src_sz    = req_sz_eff;
            src_wdata = cpu_wdata;
            src_k     = 2'd0;
        end
        beat_addr  = {src_addr[ADDR_W-1:1], 1'b0} + ADDR_W'({src_k, 1'b0});
        beat_be    = 2'b11;
        beat_wdata = (src_k == 2'd0) ? src_wdata[15:0] : src_wdata[31:16];
        if (src_sz == 2'd0) begin
            beat_be    = src_addr[0] ? 2'b10 : 2'b01;
            beat_wdata = src_addr[0] ? {src_wdata[7:0], 8'h00} : {8'h00, src_wdata[7:0]};
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_enable = 1'b0;
        case (state)
            IDLE: begin
                cpu_enable = !req_pend;
                if (req_pend) state_nxt = BEAT;
            end
            BEAT: if (beat_done && k_q == last_q) state_nxt = DONE;
            DONE: begin
                cpu_enable = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            cpu_data_in   <= '0;
            cpu_misalign  <= 1'b0;
            addr_q        <= '0;
            sz_q          <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            k_q           <= '0;
            last_q        <= '0;
        end else begin
            if (state == IDLE && req_pend) begin
                addr_q        <= cpu_addr;
                sz_q          <= req_sz_eff;
                we_q          <= !cpu_rd_en;
                wdata_q       <= cpu_wdata;
                k_q           <= 2'd0;
                last_q        <= (req_sz_eff == 2'd3) ? 2'd2 : (req_sz_eff == 2'd2) ? 2'd1 : 2'd0;
                cpu_data_in   <= '0;
                if (cpu_req_sz != 2'd0 && cpu_addr[0]) cpu_misalign <= 1'b1;
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= !cpu_rd_en;
                mem.mem_addr  <= beat_addr;
                mem.mem_wdata <= beat_wdata;
                mem.mem_be    <= beat_be;
            end
            if (beat_done) begin
                if (!we_q) begin
                    if (sz_q == 2'd0)
                        cpu_data_in[7:0] <= addr_q[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
                    else
                        cpu_data_in[{k_q, 4'b0000} +: 16] <= mem.mem_rdata;
                end
                if (k_q == last_q) begin
                    mem.mem_req <= 1'b0;
                end else begin
                    k_q           <= k_q + 2'd1;
                    mem.mem_addr  <= beat_addr;
                    mem.mem_wdata <= beat_wdata;
                    mem.mem_be    <= beat_be;
                end
            end
        end
    end
endmodule
